// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Owner encoding matches the mode_script input level.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'h00;
  localparam logic       OWNER_MANUAL      = 1'b0;
  localparam logic       OWNER_SCRIPT      = 1'b1;

endpackage

// File: rtl/uart_tx_arbiter_down_counter.sv
// Loadable down counter that saturates at zero; load wins over decrement.
// Registered count, combinational zero flag, no backpressure.
module arb_down_counter #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_count,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Grants the UART byte path to the manual or script sender, one byte at a time, owner switched only in IDLE.
// Grant lands one cycle after IDLE sees valid; requesters hold valid until their ack pulse, then wait out the gap.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2048,
  parameter logic [7:0]  IDLE_BYTE      = IDLE_BYTE_DEFAULT
) (
  input  logic       i_uart_clk,
  input  logic       i_rst_n,
  input  logic       i_mode_script,
  input  logic       i_script_loading,
  input  logic       i_man_valid,
  input  logic [7:0] i_man_bits,
  output logic       o_man_ack,
  input  logic       i_scr_valid,
  input  logic [7:0] i_scr_bits,
  output logic       o_scr_ack,
  input  logic       i_tx_ready,
  output logic [7:0] o_tx_bits,
  output logic       o_owner,
  output logic       o_busy,
  output logic       o_timeout_err,
  input  logic       i_err_clear
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  arb_state_t r_state, w_state_nxt;
  logic [7:0] r_tx_bits, w_tx_bits_nxt;
  logic       r_owner, w_owner_nxt;
  logic       r_man_ack, w_man_ack_nxt;
  logic       r_scr_ack, w_scr_ack_nxt;
  logic       r_timeout_err, w_err_nxt;

  logic          w_tmr_load, w_tmr_dec, w_tmr_zero;
  logic [TW-1:0] w_tmr_cnt;
  logic          w_gap_load, w_gap_dec, w_gap_zero;
  logic [GW-1:0] w_gap_cnt;
  logic          w_sel_vld;
  logic [7:0]    w_sel_bits;
  logic          w_unused_tmr;

  // Timer counts remaining SEND cycles; zero means TIMEOUT_CYCLES cycles have elapsed.
  arb_down_counter #(.W(TW)) u_timer (
    .i_clk      (i_uart_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (TW'(TIMEOUT_CYCLES - 1)),
    .i_dec      (w_tmr_dec),
    .o_count    (w_tmr_cnt),
    .o_zero     (w_tmr_zero)
  );

  arb_down_counter #(.W(GW)) u_gap (
    .i_clk      (i_uart_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_gap_load),
    .i_load_val (GW'(GAP_CYCLES)),
    .i_dec      (w_gap_dec),
    .o_count    (w_gap_cnt),
    .o_zero     (w_gap_zero)
  );

  assign w_unused_tmr = ^w_tmr_cnt;
  assign w_sel_vld    = i_mode_script ? i_scr_valid : i_man_valid;
  assign w_sel_bits   = i_mode_script ? i_scr_bits  : i_man_bits;

  always_ff @(posedge i_uart_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_tx_bits     <= IDLE_BYTE;
      r_owner       <= OWNER_MANUAL;
      r_man_ack     <= 1'b0;
      r_scr_ack     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_tx_bits     <= w_tx_bits_nxt;
      r_owner       <= w_owner_nxt;
      r_man_ack     <= w_man_ack_nxt;
      r_scr_ack     <= w_scr_ack_nxt;
      r_timeout_err <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_tx_bits_nxt = r_tx_bits;
    w_owner_nxt   = r_owner;
    w_man_ack_nxt = 1'b0;
    w_scr_ack_nxt = 1'b0;
    w_err_nxt     = r_timeout_err && !i_err_clear;
    w_tmr_load    = 1'b0;
    w_tmr_dec     = 1'b0;
    w_gap_load    = 1'b0;
    w_gap_dec     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        w_owner_nxt = i_mode_script;
        if (!i_script_loading && w_sel_vld) begin
          w_tx_bits_nxt = w_sel_bits;
          w_tmr_load    = 1'b1;
          w_state_nxt   = ST_SEND;
        end
      end
      ST_SEND: begin
        w_tmr_dec = 1'b1;
        // A real completion on the timeout cycle is not an error.
        if (i_tx_ready || w_tmr_zero) begin
          if (!i_tx_ready) begin
            w_err_nxt = 1'b1;
          end
          w_man_ack_nxt = (r_owner == OWNER_MANUAL);
          w_scr_ack_nxt = (r_owner == OWNER_SCRIPT);
          w_tx_bits_nxt = IDLE_BYTE;
          w_gap_load    = 1'b1;
          w_state_nxt   = ST_GAP;
        end
      end
      ST_GAP: begin
        w_gap_dec = 1'b1;
        if (w_gap_zero || (w_gap_cnt == GW'(1))) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_tx_bits     = r_tx_bits;
  assign o_owner       = r_owner;
  assign o_man_ack     = r_man_ack;
  assign o_scr_ack     = r_scr_ack;
  assign o_timeout_err = r_timeout_err;
  assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized two-queue traffic against a queue model.
module tb_uart_tx_arbiter;

  localparam int GAP = 4;
  localparam int TMO = 2048;

  logic       clk = 1'b0;
  logic       rst_n, mode, loading, mv, sv, tx_ready, err_clear;
  logic [7:0] mb, sb;
  logic       man_ack, scr_ack, owner, busy, err;
  logic [7:0] tx_bits;

  int n_chk = 0;
  int n_fail = 0;
  int man_ack_cnt = 0;
  int scr_ack_cnt = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .IDLE_BYTE(8'h00)) dut (
    .i_uart_clk(clk), .i_rst_n(rst_n), .i_mode_script(mode), .i_script_loading(loading),
    .i_man_valid(mv), .i_man_bits(mb), .o_man_ack(man_ack),
    .i_scr_valid(sv), .i_scr_bits(sb), .o_scr_ack(scr_ack),
    .i_tx_ready(tx_ready), .o_tx_bits(tx_bits), .o_owner(owner), .o_busy(busy),
    .o_timeout_err(err), .i_err_clear(err_clear)
  );

  always @(negedge clk) begin
    if (man_ack === 1'b1) man_ack_cnt++;
    if (scr_ack === 1'b1) scr_ack_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mode = 1'b0; loading = 1'b0; mv = 1'b0; sv = 1'b0;
    tx_ready = 1'b0; err_clear = 1'b0; mb = 8'h00; sb = 8'h00;
    ticks(2);
    n_chk++; if (tx_bits !== 8'h00) begin n_fail++; $display("FAIL rst_tx_bits got %h exp 00", tx_bits); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_chk++; if (owner !== 1'b0) begin n_fail++; $display("FAIL rst_owner got %b exp 0", owner); end
    n_chk++; if ({man_ack, scr_ack} !== 2'b00) begin n_fail++; $display("FAIL rst_acks got %b exp 00", {man_ack, scr_ack}); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b exp 0", err); end
    rst_n = 1'b1;
    ticks(2);
  endtask

  task automatic test_manual_send();
    int base;
    base = man_ack_cnt;
    mode = 1'b0; mv = 1'b1; mb = 8'h5A;
    tick();
    n_chk++; if (tx_bits !== 8'h5A || busy !== 1'b1) begin n_fail++; $display("FAIL man_grant got %h/%b exp 5a/1", tx_bits, busy); end
    for (int i = 0; i < 159; i++) begin
      tick();
      n_chk++; if (tx_bits !== 8'h5A || man_ack !== 1'b0) begin n_fail++; $display("FAIL man_hold c%0d got %h ack %b exp 5a ack 0", i, tx_bits, man_ack); end
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0; mv = 1'b0;
    n_chk++; if (man_ack !== 1'b1 || scr_ack !== 1'b0) begin n_fail++; $display("FAIL man_ack got %b/%b exp 1/0", man_ack, scr_ack); end
    n_chk++; if (tx_bits !== 8'h00 || busy !== 1'b1) begin n_fail++; $display("FAIL man_gap0 got %h/%b exp 00/1", tx_bits, busy); end
    for (int g = 1; g < GAP; g++) begin
      tick();
      n_chk++; if (tx_bits !== 8'h00 || busy !== 1'b1 || man_ack !== 1'b0) begin n_fail++; $display("FAIL man_gap%0d got %h busy %b ack %b exp 00 1 0", g, tx_bits, busy, man_ack); end
    end
    tick();
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL man_idle busy got %b exp 0", busy); end
    n_chk++; if (man_ack_cnt - base !== 1) begin n_fail++; $display("FAIL man_ack_count got %0d exp 1", man_ack_cnt - base); end
  endtask

  task automatic test_script_priority();
    int mbase;
    mbase = man_ack_cnt;
    mode = 1'b1; mv = 1'b1; mb = 8'h11; sv = 1'b1; sb = 8'h33;
    tick();
    n_chk++; if (tx_bits !== 8'h33 || owner !== 1'b1) begin n_fail++; $display("FAIL scr_grant got %h owner %b exp 33 1", tx_bits, owner); end
    ticks($urandom_range(5, 20));
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0; sv = 1'b0;
    n_chk++; if (scr_ack !== 1'b1 || man_ack !== 1'b0) begin n_fail++; $display("FAIL scr_ack got %b man %b exp 1 0", scr_ack, man_ack); end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_chk++; if (tx_bits === 8'h11) begin n_fail++; $display("FAIL scr_no_man c%0d got %h exp not 11", i, tx_bits); end
    end
    n_chk++; if (busy !== 1'b0 || man_ack_cnt !== mbase) begin n_fail++; $display("FAIL scr_man_wait busy %b acks %0d exp 0 %0d", busy, man_ack_cnt, mbase); end
    mv = 1'b0;
  endtask

  task automatic test_mode_toggle();
    mode = 1'b1; sv = 1'b1; sb = 8'h33; mv = 1'b1; mb = 8'hC4;
    tick();
    n_chk++; if (tx_bits !== 8'h33 || owner !== 1'b1) begin n_fail++; $display("FAIL tog_grant got %h owner %b exp 33 1", tx_bits, owner); end
    ticks(5);
    mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++; if (tx_bits !== 8'h33 || owner !== 1'b1) begin n_fail++; $display("FAIL tog_frozen c%0d got %h owner %b exp 33 1", i, tx_bits, owner); end
    end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0; sv = 1'b0;
    n_chk++; if (scr_ack !== 1'b1 || man_ack !== 1'b0) begin n_fail++; $display("FAIL tog_ack got scr %b man %b exp 1 0", scr_ack, man_ack); end
    ticks(GAP);
    n_chk++; if (owner !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL tog_idle owner %b busy %b exp 1 0", owner, busy); end
    tick();
    n_chk++; if (owner !== 1'b0 || tx_bits !== 8'hC4) begin n_fail++; $display("FAIL tog_next owner %b got %h exp 0 c4", owner, tx_bits); end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0; mv = 1'b0;
    n_chk++; if (man_ack !== 1'b1) begin n_fail++; $display("FAIL tog_man_ack got %b exp 1", man_ack); end
    ticks(GAP);
  endtask

  // kind 0: silent UART; 1: tx_ready on the timeout cycle; 2: err_clear on the timeout cycle
  task automatic test_timeout(input int kind);
    logic exp_err;
    exp_err = (kind != 1);
    mode = (kind == 1); mv = (kind != 1); sv = (kind == 1); mb = 8'hA7; sb = 8'h7A;
    tick();
    for (int i = 1; i < TMO; i++) begin
      tick();
      n_chk++; if ({man_ack, scr_ack} !== 2'b00 || busy !== 1'b1) begin n_fail++; $display("FAIL tmo%0d_hold c%0d acks %b busy %b exp 00 1", kind, i, {man_ack, scr_ack}, busy); end
    end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL tmo%0d_early err got %b exp 0", kind, err); end
    tx_ready = (kind == 1); err_clear = (kind == 2);
    tick();
    tx_ready = 1'b0; err_clear = 1'b0; mv = 1'b0; sv = 1'b0;
    n_chk++; if (err !== exp_err) begin n_fail++; $display("FAIL tmo%0d_err got %b exp %b", kind, err, exp_err); end
    n_chk++; if ({man_ack, scr_ack} !== ((kind == 1) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL tmo%0d_ack got %b", kind, {man_ack, scr_ack}); end
    n_chk++; if (tx_bits !== 8'h00) begin n_fail++; $display("FAIL tmo%0d_bits got %h exp 00", kind, tx_bits); end
    ticks(GAP);
    n_chk++; if (err !== exp_err) begin n_fail++; $display("FAIL tmo%0d_sticky got %b exp %b", kind, err, exp_err); end
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL tmo%0d_clear got %b exp 0", kind, err); end
  endtask

  task automatic test_script_loading();
    mode = 1'b0; loading = 1'b1; mv = 1'b1; mb = 8'h6E;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_chk++; if (tx_bits !== 8'h00 || busy !== 1'b0) begin n_fail++; $display("FAIL load_block c%0d got %h busy %b exp 00 0", i, tx_bits, busy); end
    end
    loading = 1'b0;
    tick();
    n_chk++; if (tx_bits !== 8'h6E || busy !== 1'b1) begin n_fail++; $display("FAIL load_grant got %h busy %b exp 6e 1", tx_bits, busy); end
    loading = 1'b1;
    ticks(3);
    n_chk++; if (tx_bits !== 8'h6E) begin n_fail++; $display("FAIL load_midsend got %h exp 6e", tx_bits); end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0; mb = 8'h9D;
    n_chk++; if (man_ack !== 1'b1) begin n_fail++; $display("FAIL load_ack got %b exp 1", man_ack); end
    ticks(GAP + 6);
    n_chk++; if (tx_bits !== 8'h00 || busy !== 1'b0) begin n_fail++; $display("FAIL load_reblock got %h busy %b exp 00 0", tx_bits, busy); end
    loading = 1'b0;
    tick();
    n_chk++; if (tx_bits !== 8'h9D) begin n_fail++; $display("FAIL load_regrant got %h exp 9d", tx_bits); end
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0; mv = 1'b0;
    ticks(GAP);
  endtask

  task automatic test_reset_mid_send();
    int base;
    base = scr_ack_cnt;
    mode = 1'b1; sv = 1'b1; sb = 8'hE1;
    tick();
    ticks(10);
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (tx_bits !== 8'h00 || busy !== 1'b0 || owner !== 1'b0) begin n_fail++; $display("FAIL rmid_async got %h busy %b owner %b exp 00 0 0", tx_bits, busy, owner); end
    tx_ready = 1'b1;
    ticks(2);
    @(negedge clk);
    rst_n = 1'b1; tx_ready = 1'b0;
    n_chk++; if (scr_ack_cnt !== base) begin n_fail++; $display("FAIL rmid_noack got %0d exp %0d", scr_ack_cnt, base); end
    tick();
    n_chk++; if (tx_bits !== 8'hE1 || owner !== 1'b1) begin n_fail++; $display("FAIL rmid_regrant got %h owner %b exp e1 1", tx_bits, owner); end
    ticks(3);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0; sv = 1'b0;
    n_chk++; if (scr_ack !== 1'b1) begin n_fail++; $display("FAIL rmid_ack got %b exp 1", scr_ack); end
    ticks(GAP);
  endtask

  // Two requester queues; mode picks which head byte goes next, the other waits untouched.
  task automatic test_back_to_back();
    logic [7:0] man_q[$];
    logic [7:0] scr_q[$];
    logic [7:0] exp_byte;
    logic       sel;
    int         exp_man, exp_scr, d, flip;
    bit         first;
    for (int i = 0; i < 8; i++) begin
      man_q.push_back(8'($urandom_range(1, 255)));
      scr_q.push_back(8'($urandom_range(1, 255)));
    end
    exp_man = man_ack_cnt + 8; exp_scr = scr_ack_cnt + 8;
    first = 1'b1;
    while (man_q.size() + scr_q.size() > 0) begin
      sel = 1'($urandom_range(0, 1));
      if (sel && scr_q.size() == 0) sel = 1'b0;
      if (!sel && man_q.size() == 0) sel = 1'b1;
      mode = sel;
      mv = (man_q.size() > 0); mb = mv ? man_q[0] : 8'h00;
      sv = (scr_q.size() > 0); sb = sv ? scr_q[0] : 8'h00;
      exp_byte = sel ? scr_q[0] : man_q[0];
      if (!first) begin
        for (int g = 1; g < GAP; g++) begin
          tick();
          n_chk++; if (busy !== 1'b1 || tx_bits !== 8'h00) begin n_fail++; $display("FAIL b2b_gap%0d busy %b got %h exp 1 00", g, busy, tx_bits); end
        end
        tick();
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle busy %b exp 0", busy); end
      end
      first = 1'b0;
      tick();
      n_chk++; if (tx_bits !== exp_byte || owner !== sel) begin n_fail++; $display("FAIL b2b_grant got %h owner %b exp %h %b", tx_bits, owner, exp_byte, sel); end
      d = $urandom_range(0, 25);
      flip = $urandom_range(0, 1);
      for (int i = 0; i < d; i++) begin
        if (flip != 0 && i == d / 2) mode = ~mode;
        tick();
        n_chk++; if (tx_bits !== exp_byte || owner !== sel) begin n_fail++; $display("FAIL b2b_hold got %h owner %b exp %h %b", tx_bits, owner, exp_byte, sel); end
      end
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      n_chk++; if (scr_ack !== sel || man_ack !== ~sel || tx_bits !== 8'h00) begin n_fail++; $display("FAIL b2b_ack scr %b man %b bits %h exp sel %b", scr_ack, man_ack, tx_bits, sel); end
      if (sel) void'(scr_q.pop_front()); else void'(man_q.pop_front());
    end
    mv = 1'b0; sv = 1'b0;
    ticks(GAP + 1);
    n_chk++; if (man_ack_cnt !== exp_man || scr_ack_cnt !== exp_scr) begin n_fail++; $display("FAIL b2b_totals man %0d scr %0d exp %0d %0d", man_ack_cnt, scr_ack_cnt, exp_man, exp_scr); end
  endtask

  initial begin
    test_reset();
    test_manual_send();
    test_script_priority();
    test_mode_toggle();
    test_timeout(0);
    test_timeout(1);
    test_timeout(2);
    test_script_loading();
    test_reset_mid_send();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
